// File: rtl/esfa_pkg.sv
// esfa_pkg: shared types for the ESFA storage cell.
//   esfa_op_e         - 4-bit opcode carried on req_op (9..15 are illegal)
//   esfa_cell_state_e - request/response FSM states
//   esfa_rec_t        - element record at the default 8-bit widths, for
//                       controller-side views of a cell's contents
package esfa_pkg;

  typedef enum logic [3:0] {
    OP_UPDATE       = 4'd0,
    OP_LOOKUP       = 4'd1,
    OP_ENCODE       = 4'd2,
    OP_CONGRUE_UP   = 4'd3,
    OP_CONGRUE_DOWN = 4'd4,
    OP_MARK_AVAIL   = 4'd5,
    OP_ENRANK       = 4'd6,
    OP_DEBUG        = 4'd7,
    OP_CLEAR        = 4'd8
  } esfa_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } esfa_cell_state_e;

  localparam int ESFA_DEF_W = 8;

  typedef struct packed {
    logic                  arr_def;
    logic                  elt_def;
    logic [ESFA_DEF_W-1:0] code;
    logic [ESFA_DEF_W-1:0] low;
    logic [ESFA_DEF_W-1:0] high;
    logic [ESFA_DEF_W-1:0] idx;
    logic [ESFA_DEF_W-1:0] val;
    logic [ESFA_DEF_W-1:0] rank;
  } esfa_rec_t;

endpackage

// File: rtl/esfa_cell_param_if.sv
// esfa_cell_param_if: request/response bus between the array controller
// (master) and one ESFA cell (slave).
//   req_valid/req_ready     request handshake (controller -> cell)
//   req_op/index/value/meta request operands, req_meta_vld qualifies req_meta
//   resp_valid/resp_ready   response handshake (cell -> controller)
//   resp_hit/value/context  opcode result, resp_err flags illegal opcodes
interface esfa_cell_param_if #(
  parameter int HANDLE_W = 8,
  parameter int IDX_W    = 8,
  parameter int DATA_W   = 8
);
  logic                req_valid;
  logic                req_ready;
  logic [3:0]          req_op;
  logic [IDX_W-1:0]    req_index;
  logic [DATA_W-1:0]   req_value;
  logic [HANDLE_W-1:0] req_meta;
  logic                req_meta_vld;
  logic                resp_valid;
  logic                resp_ready;
  logic                resp_hit;
  logic [DATA_W-1:0]   resp_value;
  logic [DATA_W-1:0]   resp_context;
  logic                resp_err;

  modport master (
    output req_valid, req_op, req_index, req_value, req_meta, req_meta_vld, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_value, resp_context, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_index, req_value, req_meta, req_meta_vld, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_value, resp_context, resp_err
  );
endinterface

// File: rtl/esfa_cell_next.sv
// esfa_cell_next: purely combinational opcode decode for one ESFA cell.
// Given the latched operands and the current (pre-op) record it produces the
// next record and the response fields. Unchanged record fields pass through.
//   handle        cell identifier
//   op_i..meta_vld_i  latched request operands
//   *_i record    current record, *_o record next record
//   hit_o/value_o/context_o/err_o  response
// Option: ESFA_CELL_DEBUG_EN enables opcode 7 (DEBUG); otherwise it is illegal.
module esfa_cell_next
  import esfa_pkg::*;
#(
  parameter int HANDLE_W   = 8,
  parameter int IDX_W      = 8,
  parameter int DATA_W     = 8,
  parameter int RANK_W     = 8,
  parameter int NUM_ARRAYS = 8
) (
  input  logic [HANDLE_W-1:0] handle,
  input  logic [3:0]          op_i,
  input  logic [IDX_W-1:0]    index_i,
  input  logic [DATA_W-1:0]   value_i,
  input  logic [HANDLE_W-1:0] meta_i,
  input  logic                meta_vld_i,
  input  logic                arr_def_i,
  input  logic                elt_def_i,
  input  logic [HANDLE_W-1:0] code_i,
  input  logic [HANDLE_W-1:0] low_i,
  input  logic [HANDLE_W-1:0] high_i,
  input  logic [IDX_W-1:0]    idx_i,
  input  logic [DATA_W-1:0]   val_i,
  input  logic [RANK_W-1:0]   rank_i,
  output logic                arr_def_o,
  output logic                elt_def_o,
  output logic [HANDLE_W-1:0] code_o,
  output logic [HANDLE_W-1:0] low_o,
  output logic [HANDLE_W-1:0] high_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic [DATA_W-1:0]   val_o,
  output logic [RANK_W-1:0]   rank_o,
  output logic                hit_o,
  output logic [DATA_W-1:0]   value_o,
  output logic [DATA_W-1:0]   context_o,
  output logic                err_o
);
  // One extra bit so NUM_ARRAYS == 2**HANDLE_W still compares correctly.
  localparam logic [HANDLE_W:0] NUM_ARR_C = (HANDLE_W+1)'(NUM_ARRAYS);

  logic meta_in_range;
  logic meta_is_self;
  logic target_is_self;
  logic owner_hit;

  assign meta_in_range  = {1'b0, meta_i} < NUM_ARR_C;
  assign meta_is_self   = meta_i == handle;
  // index and handle may differ in width; compare zero-extended
  assign target_is_self = 32'(index_i) == 32'(handle);
  assign owner_hit      = meta_vld_i && meta_in_range && arr_def_i && meta_is_self;

  always_comb begin
    arr_def_o = arr_def_i;
    elt_def_o = elt_def_i;
    code_o    = code_i;
    low_o     = low_i;
    high_o    = high_i;
    idx_o     = idx_i;
    val_o     = val_i;
    rank_o    = rank_i;
    hit_o     = 1'b0;
    value_o   = '0;
    context_o = '0;
    err_o     = 1'b0;
    case (op_i)
      OP_UPDATE: begin
        hit_o     = meta_vld_i && meta_is_self;
        value_o   = DATA_W'(handle);
        context_o = DATA_W'(handle);
        if (meta_vld_i && meta_is_self) begin
          arr_def_o = 1'b1;
          elt_def_o = 1'b1;
          code_o    = handle;
          low_o     = handle;
          high_o    = handle;
          idx_o     = index_i;
          val_o     = value_i;
          rank_o    = RANK_W'(1);
        end
      end
      OP_LOOKUP: begin
        hit_o     = (idx_i == index_i) && (low_i <= meta_i) && (meta_i <= high_i)
                    && meta_vld_i && elt_def_i;
        value_o   = val_i;
        context_o = DATA_W'(rank_i);
      end
      OP_ENCODE: begin
        hit_o     = owner_hit;
        value_o   = DATA_W'(code_i);
        context_o = DATA_W'(code_i);
      end
      OP_CONGRUE_UP: begin
        if (target_is_self && meta_vld_i) begin
          code_o = meta_i + 1'b1;
          low_o  = meta_i + 1'b1;
          high_o = meta_i + 1'b1;
          rank_o = RANK_W'(value_i + 1'b1);
        end else if (meta_vld_i) begin
          if (arr_def_i && (code_i > meta_i)) code_o = code_i + 1'b1;
          if (elt_def_i) begin
            if (low_i > meta_i)   low_o  = low_i + 1'b1;
            if (high_i >= meta_i) high_o = high_i + 1'b1;
          end
        end
      end
      OP_CONGRUE_DOWN: begin
        // The three clauses are independent and all read pre-op values.
        if (target_is_self && meta_vld_i) begin
          arr_def_o = 1'b0;
          rank_o    = '0;
        end
        if (elt_def_i && meta_vld_i) begin
          if (meta_i < low_i) begin
            low_o  = low_i - 1'b1;
            high_o = high_i - 1'b1;
          end else if (meta_i <= high_i) begin
            // a single-slot range disappears instead of going negative
            if (low_i == high_i) begin
              elt_def_o = 1'b0;
              arr_def_o = 1'b0;
            end else begin
              high_o = high_i - 1'b1;
            end
          end
        end
        if (arr_def_i && meta_vld_i && (code_i > meta_i)) code_o = code_i - 1'b1;
      end
      OP_MARK_AVAIL: begin
        hit_o     = !elt_def_i;
        value_o   = DATA_W'(handle);
        context_o = DATA_W'(handle);
      end
      OP_ENRANK: begin
        hit_o     = owner_hit;
        value_o   = DATA_W'(rank_i);
        context_o = DATA_W'(rank_i);
      end
`ifdef ESFA_CELL_DEBUG_EN
      OP_DEBUG: begin
        hit_o     = meta_in_range && meta_is_self;
        value_o   = DATA_W'({arr_def_i, elt_def_i});
        context_o = DATA_W'({arr_def_i, elt_def_i});
      end
`endif
      OP_CLEAR: begin
        arr_def_o = 1'b0;
        elt_def_o = 1'b0;
        code_o    = '0;
        low_o     = '0;
        high_o    = '0;
        idx_o     = '0;
        val_o     = '0;
        rank_o    = '0;
        hit_o     = 1'b1;
      end
      default: begin
        err_o = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/esfa_cell_param.sv
// esfa_cell_param: one ESFA storage cell. Accepts a request in IDLE, executes
// it on the following edge (record + response registered), then holds the
// response until the controller takes it.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (drops any transaction, clears record)
//   handle static cell identifier
//   bus    esfa_cell_param_if slave port (request/response handshake)
// Option: define ESFA_CELL_DEBUG_EN to enable the DEBUG opcode.
module esfa_cell_param
  import esfa_pkg::*;
#(
  parameter int HANDLE_W   = 8,
  parameter int IDX_W      = 8,
  parameter int DATA_W     = 8,
  parameter int RANK_W     = 8,
  parameter int NUM_ARRAYS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [HANDLE_W-1:0] handle,
  esfa_cell_param_if.slave    bus
);
  esfa_cell_state_e state_q, state_d;

  logic [3:0]          op_q;
  logic [IDX_W-1:0]    index_q;
  logic [DATA_W-1:0]   value_q;
  logic [HANDLE_W-1:0] meta_q;
  logic                meta_vld_q;

  logic                arr_def_q, arr_def_d;
  logic                elt_def_q, elt_def_d;
  logic [HANDLE_W-1:0] code_q, code_d;
  logic [HANDLE_W-1:0] low_q, low_d;
  logic [HANDLE_W-1:0] high_q, high_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic [RANK_W-1:0]   rank_q, rank_d;

  logic                hit_q, hit_d;
  logic [DATA_W-1:0]   rvalue_q, rvalue_d;
  logic [DATA_W-1:0]   rcontext_q, rcontext_d;
  logic                err_q, err_d;

  logic accept;
  assign accept = (state_q == IDLE) && bus.req_valid;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid)  state_d = EXEC;
      EXEC:                        state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus.req_ready    = (state_q == IDLE);
    bus.resp_valid   = (state_q == RESP);
    bus.resp_hit     = hit_q;
    bus.resp_value   = rvalue_q;
    bus.resp_context = rcontext_q;
    bus.resp_err     = err_q;
  end

  esfa_cell_next #(
    .HANDLE_W  (HANDLE_W),
    .IDX_W     (IDX_W),
    .DATA_W    (DATA_W),
    .RANK_W    (RANK_W),
    .NUM_ARRAYS(NUM_ARRAYS)
  ) u_next (
    .handle    (handle),
    .op_i      (op_q),
    .index_i   (index_q),
    .value_i   (value_q),
    .meta_i    (meta_q),
    .meta_vld_i(meta_vld_q),
    .arr_def_i (arr_def_q),
    .elt_def_i (elt_def_q),
    .code_i    (code_q),
    .low_i     (low_q),
    .high_i    (high_q),
    .idx_i     (idx_q),
    .val_i     (val_q),
    .rank_i    (rank_q),
    .arr_def_o (arr_def_d),
    .elt_def_o (elt_def_d),
    .code_o    (code_d),
    .low_o     (low_d),
    .high_o    (high_d),
    .idx_o     (idx_d),
    .val_o     (val_d),
    .rank_o    (rank_d),
    .hit_o     (hit_d),
    .value_o   (rvalue_d),
    .context_o (rcontext_d),
    .err_o     (err_d)
  );

  // operands on the accept edge; record and response on the EXEC edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      index_q    <= '0;
      value_q    <= '0;
      meta_q     <= '0;
      meta_vld_q <= 1'b0;
      arr_def_q  <= 1'b0;
      elt_def_q  <= 1'b0;
      code_q     <= '0;
      low_q      <= '0;
      high_q     <= '0;
      idx_q      <= '0;
      val_q      <= '0;
      rank_q     <= '0;
      hit_q      <= 1'b0;
      rvalue_q   <= '0;
      rcontext_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= bus.req_op;
        index_q    <= bus.req_index;
        value_q    <= bus.req_value;
        meta_q     <= bus.req_meta;
        meta_vld_q <= bus.req_meta_vld;
      end
      if (state_q == EXEC) begin
        arr_def_q  <= arr_def_d;
        elt_def_q  <= elt_def_d;
        code_q     <= code_d;
        low_q      <= low_d;
        high_q     <= high_d;
        idx_q      <= idx_d;
        val_q      <= val_d;
        rank_q     <= rank_d;
        hit_q      <= hit_d;
        rvalue_q   <= rvalue_d;
        rcontext_q <= rcontext_d;
        err_q      <= err_d;
      end
    end
  end
endmodule

// File: tb/tb_esfa_cell_param.sv
// Directed testbench for esfa_cell_param at default 8-bit widths.
module tb_esfa_cell_param;
  import esfa_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] handle = 8'h00;

  esfa_cell_param_if #(.HANDLE_W(8), .IDX_W(8), .DATA_W(8)) bus();

  esfa_cell_param #(
    .HANDLE_W(8), .IDX_W(8), .DATA_W(8), .RANK_W(8), .NUM_ARRAYS(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .handle(handle),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic       r_hit;
  logic       r_err;
  logic [7:0] r_val;
  logic [7:0] r_ctx;
  int         lat;

  task automatic idle_bus();
    bus.req_valid    = 1'b0;
    bus.req_op       = 4'd0;
    bus.req_index    = 8'h00;
    bus.req_value    = 8'h00;
    bus.req_meta     = 8'h00;
    bus.req_meta_vld = 1'b0;
    bus.resp_ready   = 1'b0;
  endtask

  // Present a request, wait for acceptance and the response, capture it.
  // lat = edges after the accept edge until resp_valid shows.
  task automatic start_txn(input logic [3:0] op, input logic [7:0] idx,
                           input logic [7:0] val, input logic [7:0] meta, input logic vld);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_index    = idx;
    bus.req_value    = val;
    bus.req_meta     = meta;
    bus.req_meta_vld = vld;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    tests++;
    if (bus.resp_valid !== 1'b1) begin
      fails++;
      $display("FAIL resp_timeout op=%0d: resp_valid=%b required 1", op, bus.resp_valid);
    end
    r_hit = bus.resp_hit;
    r_val = bus.resp_value;
    r_ctx = bus.resp_context;
    r_err = bus.resp_err;
    $display("[TB] op=%0d idx=%h val=%h meta=%h vld=%b -> hit=%b value=%h ctx=%h err=%b lat=%0d",
             op, idx, val, meta, vld, r_hit, r_val, r_ctx, r_err, lat);
  endtask

  task automatic finish_txn();
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic txn(input logic [3:0] op, input logic [7:0] idx,
                     input logic [7:0] val, input logic [7:0] meta, input logic vld);
    start_txn(op, idx, val, meta, vld);
    finish_txn();
  endtask

  task automatic test_reset();
    idle_bus();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
    tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    tests++; if (bus.resp_hit !== 1'b0) begin fails++; $display("FAIL rst_resp_hit: got %b want 0", bus.resp_hit); end
    tests++; if (bus.resp_value !== 8'h00) begin fails++; $display("FAIL rst_resp_value: got %h want 00", bus.resp_value); end
    tests++; if (bus.resp_context !== 8'h00) begin fails++; $display("FAIL rst_resp_context: got %h want 00", bus.resp_context); end
    tests++; if (bus.resp_err !== 1'b0) begin fails++; $display("FAIL rst_resp_err: got %b want 0", bus.resp_err); end

    // fill the record, then reset underneath a held response
    handle = 8'h03;
    txn(OP_UPDATE, 8'h05, 8'hAA, 8'h03, 1'b1);
    start_txn(OP_LOOKUP, 8'h05, 8'h00, 8'h03, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL midresp_reset_valid: got %b want 0", bus.resp_valid); end
    tests++; if (bus.resp_hit !== 1'b0) begin fails++; $display("FAIL midresp_reset_hit: got %b want 0", bus.resp_hit); end
    @(negedge clk);
    rst_n = 1'b1;

    txn(OP_LOOKUP, 8'h05, 8'h00, 8'h03, 1'b1);
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL post_rst_lookup_hit: got %b want 0", r_hit); end
    txn(OP_MARK_AVAIL, 8'h00, 8'h00, 8'h00, 1'b0);
    tests++; if (r_hit !== 1'b1) begin fails++; $display("FAIL post_rst_avail_hit: got %b want 1", r_hit); end
    tests++; if (r_val !== 8'h03) begin fails++; $display("FAIL post_rst_avail_val: got %h want 03", r_val); end
    tests++; if (r_ctx !== 8'h03) begin fails++; $display("FAIL post_rst_avail_ctx: got %h want 03", r_ctx); end
  endtask

  task automatic test_update_lookup();
    handle = 8'h03;
    txn(OP_UPDATE, 8'h05, 8'hAA, 8'h03, 1'b1);
    tests++; if (r_hit !== 1'b1) begin fails++; $display("FAIL upd_hit: got %b want 1", r_hit); end
    tests++; if (r_val !== 8'h03) begin fails++; $display("FAIL upd_val: got %h want 03", r_val); end
    tests++; if (r_ctx !== 8'h03) begin fails++; $display("FAIL upd_ctx: got %h want 03", r_ctx); end
    // accept edge + one more edge: resp_valid rises on the EXEC edge
    tests++; if (lat !== 1) begin fails++; $display("FAIL upd_latency: got %0d edges want 1", lat); end

    txn(OP_LOOKUP, 8'h05, 8'h00, 8'h03, 1'b1);
    tests++; if (r_hit !== 1'b1) begin fails++; $display("FAIL lkp_hit: got %b want 1", r_hit); end
    tests++; if (r_val !== 8'hAA) begin fails++; $display("FAIL lkp_val: got %h want AA", r_val); end
    tests++; if (r_ctx !== 8'h01) begin fails++; $display("FAIL lkp_ctx: got %h want 01", r_ctx); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL lkp_latency: got %0d edges want 1", lat); end

    txn(OP_LOOKUP, 8'h06, 8'h00, 8'h03, 1'b1);
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL lkp_wrong_idx_hit: got %b want 0", r_hit); end
    txn(OP_LOOKUP, 8'h05, 8'h00, 8'h03, 1'b0);
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL lkp_no_vld_hit: got %b want 0", r_hit); end

    // UPDATE aimed at another handle must not touch this record
    txn(OP_UPDATE, 8'h09, 8'h55, 8'h04, 1'b1);
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL upd_miss_hit: got %b want 0", r_hit); end
    txn(OP_LOOKUP, 8'h05, 8'h00, 8'h03, 1'b1);
    tests++; if (r_val !== 8'hAA) begin fails++; $display("FAIL upd_miss_kept_val: got %h want AA", r_val); end
  endtask

  task automatic test_congrue();
    // record: code=low=high=3, idx=5, val=AA, rank=1, both defined
    txn(OP_CONGRUE_UP, 8'h00, 8'h00, 8'h02, 1'b1);
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL cup_hit: got %b want 0", r_hit); end
    txn(OP_ENCODE, 8'h00, 8'h00, 8'h03, 1'b1);
    tests++; if (r_hit !== 1'b1) begin fails++; $display("FAIL cup_encode_hit: got %b want 1", r_hit); end
    tests++; if (r_val !== 8'h04) begin fails++; $display("FAIL cup_encode_val: got %h want 04", r_val); end
    txn(OP_LOOKUP, 8'h05, 8'h00, 8'h04, 1'b1);
    tests++; if (r_hit !== 1'b1) begin fails++; $display("FAIL cup_lkp4_hit: got %b want 1", r_hit); end
    txn(OP_LOOKUP, 8'h05, 8'h00, 8'h03, 1'b1);
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL cup_lkp3_hit: got %b want 0", r_hit); end

    txn(OP_CONGRUE_DOWN, 8'h00, 8'h00, 8'h04, 1'b1);
    txn(OP_MARK_AVAIL, 8'h00, 8'h00, 8'h00, 1'b0);
    tests++; if (r_hit !== 1'b1) begin fails++; $display("FAIL cdn_avail_hit: got %b want 1", r_hit); end
    txn(OP_ENCODE, 8'h00, 8'h00, 8'h03, 1'b1);
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL cdn_encode_hit: got %b want 0", r_hit); end

    // self-targeted CONGRUE_UP reseeds code/range/rank
    txn(OP_UPDATE, 8'h05, 8'hAA, 8'h03, 1'b1);
    txn(OP_CONGRUE_UP, 8'h03, 8'h09, 8'h07, 1'b1);
    txn(OP_ENRANK, 8'h00, 8'h00, 8'h03, 1'b1);
    tests++; if (r_hit !== 1'b1) begin fails++; $display("FAIL enrank_hit: got %b want 1", r_hit); end
    tests++; if (r_val !== 8'h0A) begin fails++; $display("FAIL enrank_val: got %h want 0A", r_val); end
    txn(OP_LOOKUP, 8'h05, 8'h00, 8'h08, 1'b1);
    tests++; if (r_hit !== 1'b1) begin fails++; $display("FAIL seed_lkp_hit: got %b want 1", r_hit); end
    tests++; if (r_ctx !== 8'h0A) begin fails++; $display("FAIL seed_lkp_ctx: got %h want 0A", r_ctx); end

    // self-targeted CONGRUE_DOWN drops arr_def and rank, keeps the element
    txn(OP_CONGRUE_DOWN, 8'h03, 8'h00, 8'h20, 1'b1);
    txn(OP_ENRANK, 8'h00, 8'h00, 8'h03, 1'b1);
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL cdn_self_enrank_hit: got %b want 0", r_hit); end
    tests++; if (r_val !== 8'h00) begin fails++; $display("FAIL cdn_self_enrank_val: got %h want 00", r_val); end
    txn(OP_LOOKUP, 8'h05, 8'h00, 8'h08, 1'b1);
    tests++; if (r_hit !== 1'b1) begin fails++; $display("FAIL cdn_self_lkp_hit: got %b want 1", r_hit); end

    // meta below the range shifts both bounds down
    txn(OP_CONGRUE_DOWN, 8'h00, 8'h00, 8'h02, 1'b1);
    txn(OP_LOOKUP, 8'h05, 8'h00, 8'h07, 1'b1);
    tests++; if (r_hit !== 1'b1) begin fails++; $display("FAIL cdn_shift_lkp7_hit: got %b want 1", r_hit); end
    txn(OP_LOOKUP, 8'h05, 8'h00, 8'h08, 1'b1);
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL cdn_shift_lkp8_hit: got %b want 0", r_hit); end
  endtask

  task automatic test_backpressure();
    int n;
    // element still defined (low=high=7): MARK_AVAIL misses
    start_txn(OP_MARK_AVAIL, 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_CLEAR;
    for (int i = 0; i < 5; i++) begin
      tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, bus.req_ready); end
      tests++; if (bus.resp_valid !== 1'b1) begin fails++; $display("FAIL bp_resp_valid[%0d]: got %b want 1", i, bus.resp_valid); end
      tests++; if (bus.resp_hit !== 1'b0 || bus.resp_value !== 8'h03 || bus.resp_context !== 8'h03) begin
        fails++;
        $display("FAIL bp_resp_stable[%0d]: got hit=%b val=%h ctx=%h want hit=0 val=03 ctx=03",
                 i, bus.resp_hit, bus.resp_value, bus.resp_context);
      end
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    // the held CLEAR is taken on the next edge
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++; if (bus.resp_valid !== 1'b1) begin fails++; $display("FAIL bp_second_resp: got %b want 1", bus.resp_valid); end
    tests++; if (bus.resp_hit !== 1'b1) begin fails++; $display("FAIL bp_clear_hit: got %b want 1", bus.resp_hit); end
    $display("[TB] op=%0d (held) -> hit=%b value=%h ctx=%h err=%b", OP_CLEAR,
             bus.resp_hit, bus.resp_value, bus.resp_context, bus.resp_err);
    finish_txn();
    txn(OP_LOOKUP, 8'h05, 8'h00, 8'h07, 1'b1);
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL clear_lkp_hit: got %b want 0", r_hit); end
    tests++; if (r_val !== 8'h00) begin fails++; $display("FAIL clear_lkp_val: got %h want 00", r_val); end
    txn(OP_MARK_AVAIL, 8'h00, 8'h00, 8'h00, 1'b0);
    tests++; if (r_hit !== 1'b1) begin fails++; $display("FAIL clear_avail_hit: got %b want 1", r_hit); end
  endtask

  task automatic test_illegal();
    handle = 8'h03;
    txn(OP_UPDATE, 8'h05, 8'hAA, 8'h03, 1'b1);
    tests++; if (r_err !== 1'b0) begin fails++; $display("FAIL legal_err: got %b want 0", r_err); end
    txn(4'd12, 8'h05, 8'h11, 8'h03, 1'b1);
    tests++; if (r_err !== 1'b1) begin fails++; $display("FAIL op12_err: got %b want 1", r_err); end
    tests++; if (r_hit !== 1'b0 || r_val !== 8'h00 || r_ctx !== 8'h00) begin
      fails++; $display("FAIL op12_result: got hit=%b val=%h ctx=%h want 0/00/00", r_hit, r_val, r_ctx);
    end
    txn(OP_LOOKUP, 8'h05, 8'h00, 8'h03, 1'b1);
    tests++; if (r_hit !== 1'b1 || r_val !== 8'hAA) begin
      fails++; $display("FAIL op12_record_kept: got hit=%b val=%h want 1/AA", r_hit, r_val);
    end
    txn(4'd15, 8'h00, 8'h00, 8'h03, 1'b1);
    tests++; if (r_err !== 1'b1) begin fails++; $display("FAIL op15_err: got %b want 1", r_err); end
    txn(OP_DEBUG, 8'h00, 8'h00, 8'h03, 1'b1);
`ifdef ESFA_CELL_DEBUG_EN
    tests++; if (r_err !== 1'b0) begin fails++; $display("FAIL dbg_err: got %b want 0", r_err); end
    tests++; if (r_hit !== 1'b1) begin fails++; $display("FAIL dbg_hit: got %b want 1", r_hit); end
    tests++; if (r_val !== 8'h03 || r_ctx !== 8'h03) begin
      fails++; $display("FAIL dbg_val: got val=%h ctx=%h want 03/03", r_val, r_ctx);
    end
`else
    tests++; if (r_err !== 1'b1) begin fails++; $display("FAIL dbg_err: got %b want 1", r_err); end
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL dbg_hit: got %b want 0", r_hit); end
    tests++; if (r_val !== 8'h00 || r_ctx !== 8'h00) begin
      fails++; $display("FAIL dbg_val: got val=%h ctx=%h want 00/00", r_val, r_ctx);
    end
`endif
  endtask

  task automatic test_wrap();
    handle = 8'hFF;
    txn(OP_UPDATE, 8'h01, 8'h01, 8'hFF, 1'b1);
    tests++; if (r_hit !== 1'b1) begin fails++; $display("FAIL wrap_upd_hit: got %b want 1", r_hit); end
    // meta=FF: high>=FF wraps to 00, low>FF false keeps FF, code>FF false keeps FF
    txn(OP_CONGRUE_UP, 8'h00, 8'h00, 8'hFF, 1'b1);
    txn(OP_ENCODE, 8'h00, 8'h00, 8'hFF, 1'b1);
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL wrap_encode_range_hit: got %b want 0", r_hit); end
    tests++; if (r_val !== 8'hFF) begin fails++; $display("FAIL wrap_code_kept: got %h want FF", r_val); end
    txn(OP_LOOKUP, 8'h01, 8'h00, 8'hFF, 1'b1);
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL wrap_lkpFF_hit: got %b want 0", r_hit); end
    txn(OP_LOOKUP, 8'h01, 8'h00, 8'h00, 1'b1);
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL wrap_lkp00_hit: got %b want 0", r_hit); end
    // meta=00: low FF->00, high 00->01, code FF->00
    txn(OP_CONGRUE_UP, 8'h00, 8'h00, 8'h00, 1'b1);
    txn(OP_LOOKUP, 8'h01, 8'h00, 8'h00, 1'b1);
    tests++; if (r_hit !== 1'b1) begin fails++; $display("FAIL wrap2_lkp00_hit: got %b want 1", r_hit); end
    txn(OP_LOOKUP, 8'h01, 8'h00, 8'h01, 1'b1);
    tests++; if (r_hit !== 1'b1) begin fails++; $display("FAIL wrap2_lkp01_hit: got %b want 1", r_hit); end
    txn(OP_LOOKUP, 8'h01, 8'h00, 8'h02, 1'b1);
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL wrap2_lkp02_hit: got %b want 0", r_hit); end
    txn(OP_ENCODE, 8'h00, 8'h00, 8'hFF, 1'b1);
    tests++; if (r_val !== 8'h00) begin fails++; $display("FAIL wrap2_code: got %h want 00", r_val); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_update_lookup();
    test_congrue();
    test_backpressure();
    test_illegal();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
